uart_tx_fifo_reader: RTL and testbench

UART transmitter that drains bytes from the upstream byte FIFO (the FIFO's read side) and serializes them onto the TX line as 8N1 frames (start, data LSB first, stop).
- Owns the FIFO read strobe: issues one single-cycle read per frame and only while the FIFO reports non-empty.
- Sits between the TX FIFO and the pad.

---
 rtl/uart_tx_fifo_reader.sv | 159 +++++++++++++++
 tb/tb_uart_tx_fifo_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_reader.sv
// 8N1 UART transmitter that pulls bytes from a FIFO read port and serialises them LSB first.
// Optional parity bit when UART_TX_PARITY_EN is defined (sense chosen by PARITY_ODD).
module uart_tx_fifo_reader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_enable,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast   = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [BaudW-1:0] BaudPenult = BaudW'(CLKS_PER_BIT - 2);
    localparam logic [2:0]       DataLast   = 3'(DATA_BITS - 1);
    localparam logic [2:0]       StopLast   = 3'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD > 1'b1) begin : gen_bad_params
        $error("uart_tx_fifo_reader: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    state_e               state_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 rd_q;
    logic                 done_q;
    logic [BaudW-1:0]     baud_q;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shift_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            done_q   <= 1'b0;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            rd_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        rd_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StFetch;
                    end
                end
                StFetch: state_q <= StLoad;
                StLoad: begin
                    shift_q  <= fifo_data[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
                    parity_q <= (^fifo_data[DATA_BITS-1:0]) ^ PARITY_ODD;
`endif
                    tx_q     <= 1'b0;
                    baud_q   <= '0;
                    bit_q    <= '0;
                    state_q  <= StStart;
                end
                StStart: begin
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == DataLast) begin
                            bit_q   <= '0;
`ifdef UART_TX_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= StParity;
`else
                            tx_q    <= 1'b1;
                            state_q <= StStop;
`endif
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                StParity: begin
                    if (baud_q == BaudLast) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        state_q <= StStop;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                StStop: begin
                    // Raise done one cycle early so the registered pulse lands on the last cycle.
                    if (baud_q == BaudPenult && bit_q == StopLast) begin
                        done_q <= 1'b1;
                    end
                    if (baud_q == BaudLast) begin
                        baud_q <= '0;
                        if (bit_q == StopLast) begin
                            bit_q   <= '0;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign fifo_read_enable = rd_q;
    assign tx               = tx_q;
    assign busy             = busy_q;
    assign tx_done          = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Directed bench for uart_tx_fifo_reader: FIFO model, frame scoreboard, reset and idle checks.
module tb_uart_tx_fifo_reader;

    localparam int unsigned Cpb       = 4;
    localparam bit          ParityOdd = 1'b0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_read_enable;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int tests = 0;
    int fails = 0;

    logic [7:0] fifo_mem [0:63];
    int pushed   = 0;
    int popped   = 0;
    int rd_count = 0;

    typedef struct {
        logic [11:0] bits;
        int          n;
    } frame_t;
    frame_t exp_q[$];

    uart_tx_fifo_reader #(
        .CLKS_PER_BIT(Cpb),
        .DATA_BITS   (8),
        .STOP_BITS   (1),
        .PARITY_ODD  (ParityOdd)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .fifo_empty      (fifo_empty),
        .fifo_data       (fifo_data),
        .fifo_read_enable(fifo_read_enable),
        .tx              (tx),
        .busy            (busy),
        .tx_done         (tx_done)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (pushed == popped);

    // Registered-read FIFO: data appears the cycle after the strobe is sampled.
    always @(posedge clk) begin
        if (fifo_read_enable) rd_count <= rd_count + 1;
        if (fifo_read_enable && popped != pushed) begin
            fifo_data <= fifo_mem[popped[5:0]];
            popped    <= popped + 1;
        end
    end

    function automatic frame_t make_frame(input logic [7:0] d);
        frame_t     f;
        logic [3:0] idx;
        f.bits = '0;
        idx    = 4'd0;
        f.bits[idx] = 1'b0;
        idx = idx + 4'd1;
        for (int i = 0; i < 8; i++) begin
            f.bits[idx] = d[i];
            idx = idx + 4'd1;
        end
`ifdef UART_TX_PARITY_EN
        f.bits[idx] = (^d) ^ ParityOdd;
        idx = idx + 4'd1;
`endif
        f.bits[idx] = 1'b1;
        idx = idx + 4'd1;
        f.n = int'(idx);
        return f;
    endfunction

    task automatic push_byte(input logic [7:0] d, input bit score);
        fifo_mem[pushed[5:0]] = d;
        pushed = pushed + 1;
        if (score) exp_q.push_back(make_frame(d));
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for a start bit, then checks every cycle of the frame against the scoreboard.
    task automatic check_frame(output int gap);
        frame_t f;
        bit     started;
        logic   exp_done;
        gap     = 0;
        started = 1'b0;
        for (int k = 0; k < 100 && !started; k++) begin
            @(negedge clk);
            if (tx === 1'b0) started = 1'b1;
            else gap++;
        end
        check("frame_start_seen", 32'(started), 32'd1);
        check("scoreboard_has_frame", 32'(exp_q.size() > 0), 32'd1);
        if (started && exp_q.size() > 0) begin
            f = exp_q.pop_front();
            for (int i = 0; i < f.n; i++) begin
                for (int c = 0; c < int'(Cpb); c++) begin
                    if (i != 0 || c != 0) @(negedge clk);
                    exp_done = (i == f.n - 1) && (c == int'(Cpb) - 1);
                    check($sformatf("tx_bit%0d_cyc%0d", i, c), 32'(tx), 32'(f.bits[i[3:0]]));
                    check($sformatf("busy_bit%0d", i), 32'(busy), 32'd1);
                    check($sformatf("tx_done_bit%0d_cyc%0d", i, c), 32'(tx_done), 32'(exp_done));
                    check($sformatf("no_read_bit%0d", i), 32'(fifo_read_enable), 32'd0);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  gap;
        int  base;
        int  bad;
        bit  started;

        // Reset held with data waiting in the FIFO.
        reset = 1'b1;
        push_byte(8'hA5, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_read", 32'(fifo_read_enable), 32'd0);
            check("rst_done", 32'(tx_done), 32'd0);
        end
        base  = rd_count;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("read_after_reset", 32'(fifo_read_enable), 32'd1);

        // 0xA5 frame.
        check_frame(gap);
        @(negedge clk);
        check("a5_busy_after", 32'(busy), 32'd0);
        check("a5_done_after", 32'(tx_done), 32'd0);
        check("a5_read_count", 32'(rd_count - base), 32'd1);

        // Back-to-back 0x00 / 0xFF.
        base = rd_count;
        push_byte(8'h00, 1'b1);
        push_byte(8'hFF, 1'b1);
        check_frame(gap);
        check_frame(gap);
        check("b2b_gap", 32'(gap), 32'd3);
        @(negedge clk);
        check("b2b_busy_after", 32'(busy), 32'd0);
        check("b2b_read_count", 32'(rd_count - base), 32'd2);

        // Long idle with empty FIFO.
        base = rd_count;
        bad  = 0;
        repeat (200) begin
            @(negedge clk);
            if (fifo_read_enable !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("idle_quiet_cycles", 32'(bad), 32'd0);
        check("idle_read_count", 32'(rd_count - base), 32'd0);

        // Reset during data bit 3 of 0x3C; that byte is dropped.
        base = rd_count;
        push_byte(8'h3C, 1'b0);
        started = 1'b0;
        for (int k = 0; k < 50 && !started; k++) begin
            @(negedge clk);
            if (tx === 1'b0) started = 1'b1;
        end
        check("abort_start_seen", 32'(started), 32'd1);
        repeat (16) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_read", 32'(fifo_read_enable), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (fifo_read_enable !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("abort_quiet_cycles", 32'(bad), 32'd0);
        check("abort_read_count", 32'(rd_count - base), 32'd1);
        push_byte(8'h3C, 1'b1);
        check_frame(gap);
        @(negedge clk);
        check("resume_busy_after", 32'(busy), 32'd0);
        check("resume_read_count", 32'(rd_count - base), 32'd2);

        // 0x07: parity bit present only when the feature is compiled in.
        base = rd_count;
        push_byte(8'h07, 1'b1);
        check_frame(gap);
        @(negedge clk);
        check("b07_busy_after", 32'(busy), 32'd0);
        check("b07_tx_after", 32'(tx), 32'd1);
        check("b07_read_count", 32'(rd_count - base), 32'd1);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
